// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating selector with valid/ready handshakes and a registered output.
// Defining RR_ARB_MUX_LOCK_EN adds In_Lock, which holds the grant for the length of a burst.
module rr_arb_mux #(
    parameter int WidthOfInputs  = 8,
    parameter int NumberOfInputs = 4,
    localparam int SelWidth = (NumberOfInputs > 1) ? $clog2(NumberOfInputs) : 1
) (
    input  logic                                      Clock,
    input  logic                                      Reset_n,
    input  logic [NumberOfInputs*WidthOfInputs-1:0]   ConcatanatedInputs,
    input  logic [NumberOfInputs-1:0]                 In_Valid,
    output logic [NumberOfInputs-1:0]                 In_Ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [NumberOfInputs-1:0]                 In_Lock,
`endif
    input  logic                                      Mode,
    input  logic [SelWidth-1:0]                       Select,
    output logic [WidthOfInputs-1:0]                  Out,
    output logic                                      Out_Valid,
    input  logic                                      Out_Ready,
    output logic [SelWidth-1:0]                       Out_Channel
);
    localparam int N = NumberOfInputs;
    localparam int W = WidthOfInputs;

    logic                load;
    logic                gnt_vld;
    logic [SelWidth-1:0] gnt_idx;
    logic [W-1:0]        gnt_data;
    logic                lock_act;

    logic [W-1:0]        out_q, out_d;
    logic [SelWidth-1:0] chan_q, chan_d;
    logic                vld_q, vld_d;
    logic [SelWidth-1:0] last_q, last_d;

`ifdef RR_ARB_MUX_LOCK_EN
    logic locked_q, locked_d;
    assign lock_act = locked_q;
`else
    assign lock_act = 1'b0;
`endif

    assign load = !vld_q || Out_Ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (lock_act) begin
            for (int i = 0; i < N; i++) begin
                if (last_q == SelWidth'(i) && In_Valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SelWidth'(i);
                end
            end
        end else if (!Mode) begin
            // Out-of-range Select matches no channel, so it yields no grant.
            for (int i = 0; i < N; i++) begin
                if (Select == SelWidth'(i) && In_Valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SelWidth'(i);
                end
            end
        end else begin
            // Scan farthest-first so the channel nearest after last_q wins.
            for (int k = N; k >= 1; k--) begin
                if (In_Valid[(int'(last_q) + k) % N]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SelWidth'((int'(last_q) + k) % N);
                end
            end
        end
    end

    assign gnt_data = ConcatanatedInputs[int'(gnt_idx)*W +: W];

    always_comb begin
        In_Ready = '0;
        if (Reset_n && load && gnt_vld) In_Ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        out_d  = out_q;
        chan_d = chan_q;
        vld_d  = vld_q;
        last_d = last_q;
`ifdef RR_ARB_MUX_LOCK_EN
        locked_d = locked_q;
`endif
        if (load) begin
            vld_d = gnt_vld;
            if (gnt_vld) begin
                out_d  = gnt_data;
                chan_d = gnt_idx;
                last_d = gnt_idx;
`ifdef RR_ARB_MUX_LOCK_EN
                locked_d = In_Lock[gnt_idx];
`endif
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_q  <= '0;
            chan_q <= '0;
            vld_q  <= 1'b0;
            last_q <= SelWidth'(N - 1);
`ifdef RR_ARB_MUX_LOCK_EN
            locked_q <= 1'b0;
`endif
        end else begin
            out_q  <= out_d;
            chan_q <= chan_d;
            vld_q  <= vld_d;
            last_q <= last_d;
`ifdef RR_ARB_MUX_LOCK_EN
            locked_q <= locked_d;
`endif
        end
    end

    assign Out         = out_q;
    assign Out_Valid   = vld_q;
    assign Out_Channel = chan_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a transaction-level model checked every cycle plus literal expectations.
module tb_rr_arb_mux;
    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [31:0] cin;
    logic [3:0]  in_valid, in_ready;
    logic        mode, out_rdy, out_vld;
    logic [1:0]  sel, out_ch;
    logic [7:0]  out_data;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [3:0]  in_lock;
`endif

    // Second instance with three channels for the out-of-range select case.
    logic [23:0] c3;
    logic [2:0]  v3, r3;
    logic        mode3, ov3, ordy3;
    logic [1:0]  sel3, och3;
    logic [7:0]  o3;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    rr_arb_mux #(.WidthOfInputs(8), .NumberOfInputs(4)) u_dut (
        .Clock(Clock), .Reset_n(Reset_n), .ConcatanatedInputs(cin),
        .In_Valid(in_valid), .In_Ready(in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
        .In_Lock(in_lock),
`endif
        .Mode(mode), .Select(sel), .Out(out_data), .Out_Valid(out_vld),
        .Out_Ready(out_rdy), .Out_Channel(out_ch)
    );

    rr_arb_mux #(.WidthOfInputs(8), .NumberOfInputs(3)) u_dut3 (
        .Clock(Clock), .Reset_n(Reset_n), .ConcatanatedInputs(c3),
        .In_Valid(v3), .In_Ready(r3),
`ifdef RR_ARB_MUX_LOCK_EN
        .In_Lock(3'b000),
`endif
        .Mode(mode3), .Select(sel3), .Out(o3), .Out_Valid(ov3),
        .Out_Ready(ordy3), .Out_Channel(och3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model of the 4-channel instance.
    int         m_last;
    bit         m_vld;
    logic [7:0] m_out;
    int         m_ch;
    bit         m_lock;

    function automatic int exp_grant();
        if (m_lock) return in_valid[m_last] ? m_last : -1;
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 1; k <= 4; k++)
            if (in_valid[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_last <= 3; m_vld <= 0; m_out <= 8'h00; m_ch <= 0; m_lock <= 0;
        end else if (!m_vld || out_rdy) begin
            int g;
            g = exp_grant();
            m_vld <= (g >= 0);
            if (g >= 0) begin
                m_out  <= cin[g*8 +: 8];
                m_ch   <= g;
                m_last <= g;
`ifdef RR_ARB_MUX_LOCK_EN
                m_lock <= in_lock[g];
`endif
            end
        end
    end

    always @(negedge Clock) begin
        if (Reset_n) begin
            int g;
            logic [3:0] er;
            g  = exp_grant();
            er = 4'b0000;
            if ((!m_vld || out_rdy) && g >= 0) er[g] = 1'b1;
            chk("model_in_ready", 32'(in_ready), 32'(er));
            chk("model_out_valid", 32'(out_vld), 32'(m_vld));
            chk("model_out", 32'(out_data), 32'(m_out));
            chk("model_out_channel", 32'(out_ch), 32'(m_ch));
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        cin = 32'h43322110;
        in_valid = 4'b1111; mode = 1'b0; sel = 2'd0; out_rdy = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
        in_lock = 4'b0000;
`endif
        c3 = 24'hC2B1A0; v3 = 3'b000; mode3 = 1'b0; sel3 = 2'd0; ordy3 = 1'b1;
        #12;
        chk("reset_out_valid", 32'(out_vld), 32'd0);
        chk("reset_out", 32'(out_data), 32'd0);
        chk("reset_out_channel", 32'(out_ch), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        step();
        Reset_n = 1'b1;

        // Select mode, selects 2,0,3,1
        sel = 2'd2; step();
        chk("sel_out0", 32'(out_data), 32'h32); chk("sel_ch0", 32'(out_ch), 32'd2);
        sel = 2'd0; step();
        chk("sel_out1", 32'(out_data), 32'h10); chk("sel_ch1", 32'(out_ch), 32'd0);
        sel = 2'd3; step();
        chk("sel_out2", 32'(out_data), 32'h43); chk("sel_ch2", 32'(out_ch), 32'd3);
        sel = 2'd1; step();
        chk("sel_out3", 32'(out_data), 32'h21); chk("sel_ch3", 32'(out_ch), 32'd1);
        chk("sel_valid", 32'(out_vld), 32'd1);

        // Asynchronous reset while a beat is held
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_vld), 32'd0);
        chk("async_rst_out", 32'(out_data), 32'd0);
        mode = 1'b1; in_valid = 4'b1111;
        Reset_n = 1'b1;

        // Round-robin fairness from reset: 0,1,2,3,0,1,2
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rr_channel", 32'(out_ch), 32'(i % 4));
            chk("rr_valid", 32'(out_vld), 32'd1);
        end
        in_valid = 4'b0101;
        step(); chk("rr_sparse0", 32'(out_ch), 32'd0);
        step(); chk("rr_sparse1", 32'(out_ch), 32'd2);

        // Backpressure on a held 0x21 beat
        in_valid = 4'b0010;
        step(); chk("bp_load", 32'(out_data), 32'h21);
        out_rdy = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp_out_hold", 32'(out_data), 32'h21);
            chk("bp_valid_hold", 32'(out_vld), 32'd1);
        end
        out_rdy = 1'b1;
        step();
        chk("bp_release_out", 32'(out_data), 32'h32);
        chk("bp_release_ch", 32'(out_ch), 32'd2);

        // Three-channel instance, Select=3 is out of range
        v3 = 3'b111; sel3 = 2'd0;
        step();
        chk("n3_out", 32'(o3), 32'hA0); chk("n3_valid", 32'(ov3), 32'd1);
        sel3 = 2'd3;
        #1 chk("n3_oor_ready", 32'(r3), 32'd0);
        chk("n3_oor_valid_before", 32'(ov3), 32'd1);
        step();
        chk("n3_oor_valid_after", 32'(ov3), 32'd0);
        chk("n3_oor_out_hold", 32'(o3), 32'hA0);
        chk("n3_oor_ch_hold", 32'(och3), 32'd0);

`ifdef RR_ARB_MUX_LOCK_EN
        // Locked burst on ch1 with a valid gap
        in_valid = 4'b0010; in_lock = 4'b0010;
        step(); chk("lock_b0", 32'(out_ch), 32'd1);
        in_valid = 4'b1100;
        step(); chk("lock_gap_valid", 32'(out_vld), 32'd0);
        in_valid = 4'b1110;
        step(); chk("lock_b1", 32'(out_ch), 32'd1);
        in_lock = 4'b0000;
        step(); chk("lock_b2", 32'(out_ch), 32'd1);
        step(); chk("lock_after0", 32'(out_ch), 32'd2);
        step(); chk("lock_after1", 32'(out_ch), 32'd3);
`endif

        in_valid = 4'b0000;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
